// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the default
// bit divider that uart_tx and uart_rx must agree on.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is a parameter so an idle-high line does not look like activity after reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB-first, mid-bit sampling on fpga_clk.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop.
import uart_pkg::*;

module uart_rx #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       fpga_clk,
  input  logic       nrst,
  input  logic       sin,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  rx_state_t r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_sh, w_sh_nxt;
  logic [DATA_BITS-1:0] r_dout, w_dout_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 r_perr, w_perr_nxt;
  logic                 w_sin_s;
  logic                 w_tick;
  logic                 w_par_bad;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (fpga_clk),
    .i_rst_n (nrst),
    .i_d     (sin),
    .o_q     (w_sin_s)
  );

  assign w_tick = (r_cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic r_pbad, w_pbad_nxt;

  always_ff @(posedge fpga_clk or negedge nrst) begin
    if (!nrst) r_pbad <= 1'b0;
    else       r_pbad <= w_pbad_nxt;
  end

  // Mismatch is latched at the parity bit and consumed at the stop bit.
  always_comb begin
    w_pbad_nxt = r_pbad;
    if (r_state == IDLE)
      w_pbad_nxt = 1'b0;
    else if (r_state == PARITY && w_tick)
      w_pbad_nxt = (w_sin_s != (^r_sh ^ PARITY_ODD));
  end

  assign w_par_bad = r_pbad;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge fpga_clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_sh    <= w_sh_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_sin_s) w_state_nxt = START;
      end
      START: begin
        // Half a bit in: a line back high was only a glitch.
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          w_state_nxt = w_sin_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          w_sh_nxt  = {w_sin_s, r_sh[DATA_BITS-1:1]};
          if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!w_sin_s) begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = BREAK;
          end else if (w_par_bad) begin
            w_perr_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_dout_nxt  = r_sh;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      BREAK: begin
        w_cnt_nxt = '0;
        if (w_sin_s) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign dout       = r_dout;
  assign rx_valid   = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign busy_rx    = (r_state != IDLE);

endmodule
